// File: rtl/bus_debug_scratch_responder_pkg.sv
// Shared definitions for the debug scratch responder: FSM encodings, default
// window base, beat counter width and the burst range check.
package bus_debug_scratch_responder_pkg;

   localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h5000_0000;
   localparam int          CNT_W             = 8;

   localparam logic [2:0] ENC_IDLE        = 3'd0;
   localparam logic [2:0] ENC_READ        = 3'd1;
   localparam logic [2:0] ENC_READ_END    = 3'd2;
   localparam logic [2:0] ENC_WRITE       = 3'd3;
   localparam logic [2:0] ENC_WRITE_DRAIN = 3'd4;
   localparam logic [2:0] ENC_ERROR       = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE        = ENC_IDLE,
      ST_READ        = ENC_READ,
      ST_READ_END    = ENC_READ_END,
      ST_WRITE       = ENC_WRITE,
      ST_WRITE_DRAIN = ENC_WRITE_DRAIN,
      ST_ERROR       = ENC_ERROR
   } state_t;

   // Integer arithmetic so the sum never wraps: a burst must end inside the RAM.
   function automatic logic burstOverruns(input int firstIdx, input int lastOffset,
                                          input int wordAddrBits);
      return (firstIdx + lastOffset) > ((1 << wordAddrBits) - 1);
   endfunction

endpackage

// File: rtl/bus_debug_scratch_responder_if.sv
// System bus seen by a single target: initiator-driven *IN signals and
// responder-driven *OUT signals.
interface bus_debug_scratch_responder_if;
   import bus_debug_scratch_responder_pkg::*;

   logic [31:0]      address_dataIN;
   logic [3:0]       byte_enablesIN;
   logic [CNT_W-1:0] burst_sizeIN;
   logic             read_n_writeIN;
   logic             begin_transactionIN;
   logic             end_transactionIN;
   logic             data_validIN;
   logic             busyIN;

   logic [31:0]      address_dataOUT;
   logic             end_transactionOUT;
   logic             data_validOUT;
   logic             busyOUT;
   logic             errorOUT;

   modport master (
      output address_dataIN, byte_enablesIN, burst_sizeIN, read_n_writeIN,
             begin_transactionIN, end_transactionIN, data_validIN, busyIN,
      input  address_dataOUT, end_transactionOUT, data_validOUT, busyOUT, errorOUT
   );

   modport slave (
      input  address_dataIN, byte_enablesIN, burst_sizeIN, read_n_writeIN,
             begin_transactionIN, end_transactionIN, data_validIN, busyIN,
      output address_dataOUT, end_transactionOUT, data_validOUT, busyOUT, errorOUT
   );

endinterface

// File: rtl/bus_debug_scratch_responder_scratch_ram.sv
// Single-port-style scratch RAM: one-cycle synchronous read, byte-enabled
// synchronous write, written so block RAM inference is straightforward.
module bus_scratch_ram #(
   parameter int ADDR_BITS = 6
) (
   input  logic                 clk,
   input  logic [ADDR_BITS-1:0] i_rdAddr,
   output logic [31:0]          o_rdData,
   input  logic                 i_wrEn,
   input  logic [ADDR_BITS-1:0] i_wrAddr,
   input  logic [3:0]           i_wrBe,
   input  logic [31:0]          i_wrData
);

   logic [31:0] r_mem [0:(1 << ADDR_BITS) - 1];

   always_ff @(posedge clk) begin
      if (i_wrEn) begin
         for (int b = 0; b < 4; b++) begin
            if (i_wrBe[b]) begin
               r_mem[i_wrAddr][8*b +: 8] <= i_wrData[8*b +: 8];
            end
         end
      end
      o_rdData <= r_mem[i_rdAddr];
   end

endmodule

// File: rtl/bus_debug_scratch_responder.sv
// Bus target serving single/burst reads and writes from a scratch RAM inside a
// fixed address window; all outputs are zero unless this target is responding.
module bus_debug_scratch_responder
   import bus_debug_scratch_responder_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR      = DEFAULT_BASE_ADDR,
   parameter int          WORD_ADDR_BITS = 6
) (
   input  logic                          system_clock,
   input  logic                          system_reset,
   bus_debug_scratch_responder_if.slave  bus
);

   localparam int TAG_LSB = WORD_ADDR_BITS + 2;

   state_t                    r_state;
   state_t                    w_nextState;
   logic [WORD_ADDR_BITS-1:0] r_idx;
   logic [WORD_ADDR_BITS-1:0] w_nextIdx;
   logic [WORD_ADDR_BITS-1:0] w_reqIdx;
   logic [WORD_ADDR_BITS-1:0] w_rdAddr;
   logic [CNT_W-1:0]          r_remaining;
   logic [CNT_W-1:0]          w_nextRemaining;
   logic                      r_rnw;
   logic                      w_nextRnw;
   logic [3:0]                r_be;
   logic [3:0]                w_nextBe;
   logic                      r_dataValid;
   logic                      w_nextDataValid;
   logic                      r_endOut;
   logic                      w_nextEnd;
   logic                      r_errorOut;
   logic                      w_nextError;
   logic                      w_hit;
   logic                      w_reqError;
   logic                      w_wrEn;
   logic [31:0]               w_rdData;

   assign w_reqIdx   = bus.address_dataIN[TAG_LSB-1:2];
   assign w_hit      = bus.begin_transactionIN &&
                       (bus.address_dataIN[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
   assign w_reqError = (bus.address_dataIN[1:0] != 2'b00) ||
                       burstOverruns(int'(w_reqIdx), int'(bus.burst_sizeIN), WORD_ADDR_BITS);

   always_comb begin
      w_nextState     = r_state;
      w_nextIdx       = r_idx;
      w_nextRemaining = r_remaining;
      w_nextRnw       = r_rnw;
      w_nextBe        = r_be;
      w_nextDataValid = 1'b0;
      w_nextEnd       = 1'b0;
      w_nextError     = 1'b0;
      w_rdAddr        = r_idx;
      w_wrEn          = 1'b0;

      unique case (r_state)
         ST_IDLE: begin
            if (w_hit) begin
               w_nextIdx       = w_reqIdx;
               w_nextRemaining = bus.burst_sizeIN;
               w_nextRnw       = bus.read_n_writeIN;
               w_nextBe        = bus.byte_enablesIN;
               if (w_reqError) begin
                  w_nextState = ST_ERROR;
                  w_nextEnd   = 1'b1;
                  w_nextError = 1'b1;
               end else if (bus.read_n_writeIN) begin
                  w_nextState = ST_READ;
               end else begin
                  w_nextState = ST_WRITE;
               end
            end
         end

         // The RAM address runs one beat ahead so an accepted beat is followed
         // immediately by the next word; a stalled beat re-reads the same word.
         ST_READ: begin
            if (bus.end_transactionIN) begin
               w_nextState = ST_IDLE;
            end else if (!r_dataValid || bus.busyIN) begin
               w_nextDataValid = 1'b1;
            end else if (r_remaining == '0) begin
               w_nextState = ST_READ_END;
               w_nextEnd   = 1'b1;
            end else begin
               w_nextIdx       = r_idx + WORD_ADDR_BITS'(1);
               w_nextRemaining = r_remaining - CNT_W'(1);
               w_rdAddr        = r_idx + WORD_ADDR_BITS'(1);
               w_nextDataValid = 1'b1;
            end
         end

         ST_READ_END: begin
            w_nextState = ST_IDLE;
         end

         ST_WRITE: begin
            if (bus.data_validIN) begin
               w_wrEn    = 1'b1;
               w_nextIdx = r_idx + WORD_ADDR_BITS'(1);
               if (r_remaining == '0) begin
                  w_nextState = ST_WRITE_DRAIN;
               end else begin
                  w_nextRemaining = r_remaining - CNT_W'(1);
               end
            end
            if (bus.end_transactionIN) begin
               w_nextState = ST_IDLE;
            end
         end

         ST_WRITE_DRAIN: begin
            if (bus.end_transactionIN) begin
               w_nextState = ST_IDLE;
            end
         end

         ST_ERROR: begin
            w_nextState = r_rnw ? ST_IDLE : ST_WRITE_DRAIN;
         end

         default: begin
            w_nextState = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge system_clock or posedge system_reset) begin
      if (system_reset) begin
         r_state     <= ST_IDLE;
         r_idx       <= '0;
         r_remaining <= '0;
         r_rnw       <= 1'b0;
         r_be        <= '0;
         r_dataValid <= 1'b0;
         r_endOut    <= 1'b0;
         r_errorOut  <= 1'b0;
      end else begin
         r_state     <= w_nextState;
         r_idx       <= w_nextIdx;
         r_remaining <= w_nextRemaining;
         r_rnw       <= w_nextRnw;
         r_be        <= w_nextBe;
         r_dataValid <= w_nextDataValid;
         r_endOut    <= w_nextEnd;
         r_errorOut  <= w_nextError;
      end
   end

   bus_scratch_ram #(
      .ADDR_BITS (WORD_ADDR_BITS)
   ) u_ram (
      .clk      (system_clock),
      .i_rdAddr (w_rdAddr),
      .o_rdData (w_rdData),
      .i_wrEn   (w_wrEn),
      .i_wrAddr (r_idx),
      .i_wrBe   (r_be),
      .i_wrData (bus.address_dataIN)
   );

   // The RAM output register only reaches the shared bus while a beat is valid.
   assign bus.address_dataOUT    = r_dataValid ? w_rdData : 32'h0;
   assign bus.data_validOUT      = r_dataValid;
   assign bus.end_transactionOUT = r_endOut;
   assign bus.errorOUT           = r_errorOut;
   assign bus.busyOUT            = 1'b0;

endmodule

// File: tb/tb_bus_debug_scratch_responder.sv
// Self-checking bench: directed scenarios plus random transactions, checked
// cycle by cycle against a word-array model of the scratch window.
module tb_bus_debug_scratch_responder;

   logic clk;
   logic rst;

   bus_debug_scratch_responder_if busIf ();

   bus_debug_scratch_responder dut (
      .system_clock (clk),
      .system_reset (rst),
      .bus          (busIf.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          compared   = 0;
   int          mismatched = 0;
   logic [31:0] ramModel [64];
   logic [31:0] wrData [260];
   logic [31:0] lastReadData;

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: observed %h, expected %h at %0t", tag, observed, expected, $time);
      end
   endtask

   function automatic logic [63:0] outVec();
      return {28'h0, busIf.errorOUT, busIf.end_transactionOUT, busIf.data_validOUT,
              busIf.busyOUT, busIf.address_dataOUT};
   endfunction

   function automatic logic [63:0] expOut(input logic err, input logic endo,
                                          input logic valid, input logic [31:0] data);
      return {28'h0, err, endo, valid, 1'b0, data};
   endfunction

   function automatic logic [31:0] mergeBe(input logic [31:0] old, input logic [31:0] data,
                                           input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = data[8*b +: 8];
      return r;
   endfunction

   function automatic bit isHit(input logic [31:0] addr);
      return addr[31:8] == 24'h500000;
   endfunction

   function automatic bit isErr(input logic [31:0] addr, input int burst);
      int idx;
      idx = int'(addr[7:2]);
      return (addr[1:0] != 2'b00) || (idx + burst > 63);
   endfunction

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idleInputs();
      busIf.address_dataIN      = $urandom;
      busIf.byte_enablesIN      = 4'($urandom);
      busIf.burst_sizeIN        = 8'($urandom);
      busIf.read_n_writeIN      = 1'($urandom);
      busIf.begin_transactionIN = 1'b0;
      busIf.end_transactionIN   = 1'b0;
      busIf.data_validIN        = 1'b0;
      busIf.busyIN              = 1'b0;
   endtask

   task automatic applyStimulus(input logic [31:0] addr, input int burst, input logic rnw,
                                input logic [3:0] be);
      busIf.begin_transactionIN = 1'b1;
      busIf.address_dataIN      = addr;
      busIf.burst_sizeIN        = burst[7:0];
      busIf.read_n_writeIN      = rnw;
      busIf.byte_enablesIN      = be;
   endtask

   task automatic doRead(input logic [31:0] addr, input int burst, input int stallBeat,
                         input int stallLen, input int busyPct, input int abortBeat);
      int  idx;
      int  k;
      int  stallCnt;
      bit  busy;
      bit  done;
      idx = int'(addr[7:2]);
      applyStimulus(addr, burst, 1'b1, 4'($urandom));
      nextCycle();
      idleInputs();
      if (!isHit(addr)) begin
         for (int i = 0; i < 3; i++) begin
            checkOutput("rd_nohit", outVec(), 64'h0);
            nextCycle();
         end
         return;
      end
      if (isErr(addr, burst)) begin
         checkOutput("rd_err", outVec(), expOut(1'b1, 1'b1, 1'b0, 32'h0));
         nextCycle();
         checkOutput("rd_err_after", outVec(), 64'h0);
         return;
      end
      checkOutput("rd_latency", outVec(), 64'h0);
      nextCycle();
      k = 0;
      stallCnt = 0;
      done = 1'b0;
      for (int guard = 0; guard < 1000 && !done; guard++) begin
         checkOutput("rd_beat", outVec(), expOut(1'b0, 1'b0, 1'b1, ramModel[idx + k]));
         lastReadData = busIf.address_dataOUT;
         if (k == abortBeat) begin
            busIf.end_transactionIN = 1'b1;
            nextCycle();
            busIf.end_transactionIN = 1'b0;
            checkOutput("rd_abort", outVec(), 64'h0);
            nextCycle();
            checkOutput("rd_abort_quiet", outVec(), 64'h0);
            return;
         end
         if (k == stallBeat && stallCnt < stallLen) begin
            busy = 1'b1;
            stallCnt++;
         end else begin
            busy = ($urandom_range(0, 99) < busyPct);
         end
         busIf.busyIN = busy;
         nextCycle();
         busIf.busyIN = 1'b0;
         if (!busy) begin
            k++;
            if (k > burst) done = 1'b1;
         end
      end
      if (!done) begin
         checkOutput("rd_timeout", 64'h1, 64'h0);
         return;
      end
      checkOutput("rd_end", outVec(), expOut(1'b0, 1'b1, 1'b0, 32'h0));
      nextCycle();
      checkOutput("rd_idle", outVec(), 64'h0);
   endtask

   task automatic doWrite(input logic [31:0] addr, input int burst, input logic [3:0] be,
                          input int nWords, input int gapPct, input int strayPct);
      int idx;
      int count;
      int sent;
      int guard;
      bit hit;
      bit err;
      bit first;
      idx = int'(addr[7:2]);
      hit = isHit(addr);
      err = hit && isErr(addr, burst);
      applyStimulus(addr, burst, 1'b0, be);
      nextCycle();
      idleInputs();
      first = 1'b1;
      count = 0;
      sent  = 0;
      guard = 0;
      while (sent < nWords && guard < 3000) begin
         guard++;
         if (first && err) checkOutput("wr_err", outVec(), expOut(1'b1, 1'b1, 1'b0, 32'h0));
         else              checkOutput("wr_quiet", outVec(), 64'h0);
         first = 1'b0;
         if ($urandom_range(0, 99) < gapPct) begin
            if (hit && $urandom_range(0, 99) < strayPct) begin
               busIf.begin_transactionIN = 1'b1;
               busIf.address_dataIN      = {24'h500000, 6'($urandom), 2'b00};
            end
         end else begin
            busIf.data_validIN   = 1'b1;
            busIf.address_dataIN = wrData[sent];
            if (hit && !err && count <= burst) begin
               ramModel[idx + count] = mergeBe(ramModel[idx + count], wrData[sent], be);
               count++;
            end
            sent++;
         end
         nextCycle();
         idleInputs();
      end
      if (sent < nWords) checkOutput("wr_timeout", 64'h1, 64'h0);
      checkOutput("wr_last", outVec(), 64'h0);
      busIf.end_transactionIN = 1'b1;
      nextCycle();
      idleInputs();
      checkOutput("wr_done", outVec(), 64'h0);
   endtask

   initial begin
      int          burst;
      int          nWords;
      logic [31:0] addr;
      rst = 1'b1;
      idleInputs();
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_out", outVec(), 64'h0);
      @(negedge clk);
      rst = 1'b0;
      nextCycle();
      checkOutput("after_reset", outVec(), 64'h0);

      // Fill the whole window with one maximum-length burst ending at word 63.
      for (int i = 0; i < 64; i++) wrData[i] = $urandom;
      for (int i = 0; i < 64; i++) ramModel[i] = 32'h0;
      doWrite(32'h5000_0000, 63, 4'hF, 64, 0, 0);
      doRead(32'h5000_0000, 63, -1, 0, 20, -1);

      wrData[0] = 32'hDEADBEEF;
      doWrite(32'h5000_0010, 0, 4'hF, 1, 0, 0);
      doRead(32'h5000_0010, 0, -1, 0, 0, -1);
      checkOutput("single_data", {32'h0, lastReadData}, {32'h0, 32'hDEADBEEF});

      wrData[0] = 32'h11; wrData[1] = 32'h22; wrData[2] = 32'h33; wrData[3] = 32'h44;
      doWrite(32'h5000_0000, 3, 4'hF, 4, 30, 50);
      doRead(32'h5000_0000, 3, 2, 2, 0, -1);

      wrData[0] = 32'hAABBCCDD;
      doWrite(32'h5000_0014, 0, 4'hF, 1, 0, 0);
      wrData[0] = 32'h11223344;
      doWrite(32'h5000_0014, 0, 4'b0101, 1, 0, 0);
      doRead(32'h5000_0014, 0, -1, 0, 0, -1);
      checkOutput("be_merge", {32'h0, lastReadData}, {32'h0, 32'hAA22CC44});

      doRead(32'h5000_0002, 0, -1, 0, 0, -1);
      for (int i = 0; i < 4; i++) wrData[i] = $urandom;
      doWrite(32'h5000_00F8, 3, 4'hF, 4, 0, 0);
      doRead(32'h5000_00F0, 3, -1, 0, 0, -1);
      doRead(32'h5000_00FC, 0, -1, 0, 0, -1);

      doRead(32'h6000_0000, 0, -1, 0, 0, -1);
      doRead(32'h5000_0000, 7, -1, 0, 0, 2);

      for (int i = 0; i < 3; i++) wrData[i] = $urandom;
      doWrite(32'h5000_0080, 5, 4'hF, 3, 0, 0);
      doRead(32'h5000_0080, 5, -1, 0, 0, -1);

      // Asynchronous reset in the middle of a read burst.
      applyStimulus(32'h5000_0000, 3, 1'b1, 4'hF);
      nextCycle();
      idleInputs();
      nextCycle();
      checkOutput("rst_beat0", outVec(), expOut(1'b0, 1'b0, 1'b1, ramModel[0]));
      nextCycle();
      checkOutput("rst_beat1", outVec(), expOut(1'b0, 1'b0, 1'b1, ramModel[1]));
      #2;
      rst = 1'b1;
      #1;
      checkOutput("rst_async", outVec(), 64'h0);
      @(posedge clk);
      #1;
      checkOutput("rst_held", outVec(), 64'h0);
      @(negedge clk);
      rst = 1'b0;
      nextCycle();
      checkOutput("rst_release", outVec(), 64'h0);
      doRead(32'h5000_0000, 3, -1, 0, 0, -1);

      for (int t = 0; t < 80; t++) begin
         case ($urandom_range(0, 9))
            0:       addr = {4'h6 + 4'($urandom_range(0, 3)), 28'($urandom)};
            1:       addr = {24'h500000, 6'($urandom), 2'($urandom_range(1, 3))};
            default: addr = {24'h500000, 6'($urandom), 2'b00};
         endcase
         burst = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 7);
         if ($urandom_range(0, 1) == 1) begin
            doRead(addr, burst, -1, 0, 30,
                   ($urandom_range(0, 4) == 0) ? $urandom_range(0, burst) : -1);
         end else begin
            case ($urandom_range(0, 3))
               0:       nWords = $urandom_range(1, burst + 1);
               1:       nWords = burst + 2;
               default: nWords = burst + 1;
            endcase
            for (int i = 0; i < nWords; i++) wrData[i] = $urandom;
            doWrite(addr, burst, 4'($urandom), nWords, 25, 30);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/bus_debug_scratch_responder.md
Name: bus_debug_scratch_responder

Overview:
- Bus responder (target) for the system bus that the JTAG debug bridge drives as initiator.
- Decodes a fixed address window and serves single and burst reads and writes from a byte-enabled scratch RAM.
- Gives the debug path a known-good target for bring-up, and lets the debugger exchange mailbox data with software.
- Sits on the shared bus next to other targets. All outputs are zero when not selected, so they can be OR-combined.

Parameters:
- BASE_ADDR, 32'h5000_0000, window base; must be aligned to the window size.
- WORD_ADDR_BITS, 6, log2 of RAM depth in 32-bit words (default 64 words = 256 bytes).

Ports:
- system_clock  in  1  single clock for the whole block.
- system_reset  in  1  asynchronous, active-high reset.
- address_dataIN  in  32  multiplexed address (with begin) / write data (with data_valid).
- byte_enablesIN  in  4  byte lanes, sampled with begin_transactionIN.
- burst_sizeIN  in  8  burst length minus 1, sampled with begin.
- read_n_writeIN  in  1  1 = read, sampled with begin.
- begin_transactionIN  in  1  one-cycle start strobe.
- end_transactionIN  in  1  initiator end of write, or initiator abort.
- data_validIN  in  1  write data strobe.
- busyIN  in  1  initiator stall during a read burst.
- address_dataOUT  out  32  read data; 0 when data_validOUT is low.
- end_transactionOUT  out  1  responder end of read or error.
- data_validOUT  out  1  read data strobe.
- busyOUT  out  1  responder stall; held 0 by this design.
- errorOUT  out  1  error response.

Behaviour:
- Reset (async, active-high):
  - All outputs 0, FSM to IDLE, counters cleared.
  - RAM contents are not reset.
  - Reset mid-burst abandons the transfer, with no further strobes.
- Outputs are registered and are 0 in every cycle the block is not driving them.
- Hit: begin_transactionIN=1 and address_dataIN[31:WORD_ADDR_BITS+2] == BASE_ADDR[31:WORD_ADDR_BITS+2]. No hit means the FSM stays in IDLE and ignores the cycle.
- Latched on a hit:
  - idx = address_dataIN[WORD_ADDR_BITS+1:2]
  - remaining = burst_sizeIN
  - rnw, and be = byte_enablesIN
- Error on a hit if either:
  - address_dataIN[1:0] != 0, or
  - idx + burst_sizeIN > 2^WORD_ADDR_BITS - 1 (computed 9+ bits wide, no wrap).
- FSM states: IDLE, READ, READ_END, WRITE, WRITE_DRAIN, ERROR.
- IDLE:
  - Hit with error -> ERROR.
  - Hit with rnw=1 -> READ.
  - Hit with rnw=0 -> WRITE.
- READ:
  - First data_validOUT appears 2 cycles after begin (cycle N begin, N+1 RAM read, N+2 data).
  - Each beat: data_validOUT=1, address_dataOUT=RAM[idx] with all 4 bytes (byte enables ignored on reads).
  - busyIN=1 in a cycle holds the current beat; data and valid stay stable and idx does not advance.
  - After each accepted beat (busyIN=0): idx+1, remaining-1.
  - After the beat accepted with remaining==0 -> READ_END.
- READ_END: end_transactionOUT=1 for exactly one cycle, data_validOUT=0, then IDLE.
- WRITE:
  - Each data_validIN=1 writes address_dataIN into RAM[idx] under the latched be, then idx+1.
  - Once burst_size+1 words are written -> WRITE_DRAIN.
  - end_transactionIN before that (short burst) -> IDLE; words already written stay written.
- WRITE_DRAIN:
  - Further data_validIN is ignored, with no RAM write.
  - end_transactionIN -> IDLE.
- ERROR:
  - errorOUT=1 and end_transactionOUT=1 together for one cycle, at N+1 after begin.
  - Then IDLE for a read, or WRITE_DRAIN for a write (waits for end_transactionIN).
  - The RAM is never modified on an errored transaction.
- end_transactionIN during READ (abort): go to IDLE; outputs are 0 from the next cycle; no end_transactionOUT.
- begin_transactionIN while not in IDLE is ignored (protocol violation by the initiator).
- Same-cycle write of RAM[k] and read of RAM[k] cannot occur; one transaction runs at a time.

Decomposition:
- Shared include/package bus_resp_defs holds:
  - FSM state encodings (3-bit localparams),
  - the default base address constant,
  - the burst/beat counter width (8).
- One sub-module, bus_scratch_ram:
  - 2^WORD_ADDR_BITS x 32,
  - synchronous read (1 cycle), byte-enabled synchronous write,
  - inferable as EBR.

Test Plan:
- Single write then read: write 0x5000_0010, burst 0, be=4'hF, data 0xDEADBEEF. Then read 0x5000_0010 -> data_validOUT at N+2 with 0xDEADBEEF, end_transactionOUT at N+3, errorOUT=0.
- Burst read with stall: preload words 0..3 = 0x11,0x22,0x33,0x44; read 0x5000_0000, burst 3; busyIN=1 during beat 2 for 2 cycles -> sequence 0x11,0x22,0x33(held 3 cycles),0x44, then end_transactionOUT for one cycle.
- Byte enables: word 5 = 0xAABBCCDD; write 0x5000_0014, be=4'b0101, data 0x11223344 -> read back 0xAA22CC44.
- Errors, each -> errorOUT+end_transactionOUT at N+1 and RAM unchanged:
  - Read 0x5000_0002.
  - Write 0x5000_00F8 with burst 3 (idx 62+3 > 63); write data is subsequently ignored until end_transactionIN.
- Non-hit and abort:
  - Read 0x6000_0000 -> all outputs stay 0.
  - Read burst 7 at 0x5000_0000 with end_transactionIN at the 3rd beat -> outputs 0 next cycle, no end_transactionOUT.
- Reset mid-burst: assert system_reset asynchronously during beat 1 of a burst-3 read -> all outputs 0 immediately. Next read at 0x5000_0000 works normally with N+2 latency.
